sphere_stats_32bit: RTL



---
 rtl/sphere_stats_32bit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sphere_stats_32bit.sv
//==============================================================================
// Module   : sphere_stats_32bit
// Summary  : Pulls N Q1.31 sphere points from the generator and bins them by
//            octant and z band; with SPHERE_STATS_RADIUS_EN defined it also
//            checks radius^2 against unit-sphere bounds.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sphere_stats_32bit #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] Z_THRESH = 32'h0CCCCCCD,
    parameter logic [31:0] R2_LO    = 32'd858993459,
    parameter logic [31:0] R2_HI    = 32'd1288490189
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    output logic             pop_enable,
    input  logic [31:0]      sphere_x,
    input  logic [31:0]      sphere_y,
    input  logic [31:0]      sphere_z,
    input  logic             in_valid,
    output logic             busy,
    output logic             done,
    input  logic [3:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data
);

`ifdef SPHERE_STATS_RADIUS_EN
    localparam int PIPE_D = 2;
`else
    localparam int PIPE_D = 1;
`endif

    localparam int NUM_CNT   = 13;
    localparam int IDX_POSZ  = 8;
    localparam int IDX_NEGZ  = 9;
    localparam int IDX_NEARZ = 10;
    localparam int IDX_RFAIL = 11;
    localparam int IDX_TOTAL = 12;

    localparam logic signed [31:0] Z_POS = Z_THRESH;
    localparam logic signed [31:0] Z_NEG = -$signed(Z_THRESH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] accepted_q;
    logic             drain_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q [NUM_CNT];
    logic [CNT_W-1:0] cnt_d [NUM_CNT];
    logic [CNT_W-1:0] rd_data_q;

    logic                  w_accept;
    logic                  w_start_ok;
    logic [2:0]            w_oct;
    logic                  w_zpos;
    logic                  w_zneg;
    logic                  w_r2_fail;
    logic [NUM_CNT-1:0]    w_inc;
    logic [CNT_W-1:0]      w_rd;

    assign pop_enable = (state_q == S_RUN) && (accepted_q < target_q);
    assign w_accept   = in_valid && pop_enable;
    assign w_start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_data    = rd_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            target_q   <= '0;
            accepted_q <= '0;
            drain_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        target_q   <= num_samples;
                        accepted_q <= '0;
                        if (num_samples == '0) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        accepted_q <= accepted_q + CNT_W'(1);
                    end
                    if (accepted_q == target_q) begin
                        state_q <= S_DRAIN;
                        drain_q <= 1'(PIPE_D - 1);
                    end
                end
                default: begin
                    // Hold in DRAIN until the last accepted point has hit every counter.
                    if (drain_q == 1'b0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign w_oct  = {sphere_z[31], sphere_y[31], sphere_x[31]};
    assign w_zpos = $signed(sphere_z) > Z_POS;
    assign w_zneg = $signed(sphere_z) < Z_NEG;

`ifdef SPHERE_STATS_RADIUS_EN
    logic signed [31:0] w_xh, w_yh, w_zh;
    logic signed [31:0] sq_x_q, sq_y_q, sq_z_q;
    logic               sq_vld_q;
    logic [33:0]        w_r2;
    logic               w_unused;

    assign w_xh = {{16{sphere_x[31]}}, sphere_x[31:16]};
    assign w_yh = {{16{sphere_y[31]}}, sphere_y[31:16]};
    assign w_zh = {{16{sphere_z[31]}}, sphere_z[31:16]};
    assign w_unused = ^{sphere_x[15:0], sphere_y[15:0], sphere_z[15:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_vld_q <= 1'b0;
            sq_x_q   <= '0;
            sq_y_q   <= '0;
            sq_z_q   <= '0;
        end else begin
            sq_vld_q <= w_accept;
            if (w_accept) begin
                sq_x_q <= w_xh * w_xh;
                sq_y_q <= w_yh * w_yh;
                sq_z_q <= w_zh * w_zh;
            end
        end
    end

    // Squares are never negative, so zero extension to 34 bits is exact.
    assign w_r2 = {2'b00, sq_x_q} + {2'b00, sq_y_q} + {2'b00, sq_z_q};
    assign w_r2_fail = sq_vld_q &&
                       ((w_r2 < {2'b00, R2_LO}) || (w_r2 > {2'b00, R2_HI}));
`else
    logic w_unused;
    assign w_unused  = ^{sphere_x[30:0], sphere_y[30:0], sphere_z[30:0]};
    assign w_r2_fail = 1'b0;
`endif

    always_comb begin
        w_inc = '0;
        if (w_accept) begin
            w_inc[w_oct]     = 1'b1;
            w_inc[IDX_POSZ]  = w_zpos;
            w_inc[IDX_NEGZ]  = w_zneg;
            w_inc[IDX_NEARZ] = !w_zpos && !w_zneg;
            w_inc[IDX_TOTAL] = 1'b1;
        end
        w_inc[IDX_RFAIL] = w_r2_fail;
    end

    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (w_start_ok) begin
                cnt_d[i] = '0;
            end else if (w_inc[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign w_rd = (rd_sel < 4'd13) ? cnt_q[rd_sel] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= w_rd;
        end
    end

endmodule

`default_nettype wire
